// File: rtl/lcd_result_formatter.sv
// Captures a 16-bit result on a show_result rising edge, converts it to decimal
// with a sequential double-dabble engine and streams sign + five digits to the LCD.
module lcd_result_formatter #(
    parameter int          SIGNED_MODE = 1,
    parameter int unsigned START_POS   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        show_result,
    output logic [7:0]  char_data,
    output logic [3:0]  char_pos,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CONVERT, EMIT, DONE} state_t;

    state_t      state, state_nx;
    logic        show_q;
    logic        neg;
    logic [15:0] mag;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;
    logic [3:0]  cnt;
    logic [2:0]  idx;
    logic        trigger;
    logic        neg_in;
    logic [15:0] mag_in;
    logic [3:0]  zpre;

    function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int n = 0; n < 5; n++) begin
            if (r[n*4 +: 4] >= 4'd5)
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
        return blank ? 8'h20 : {4'h3, d};
    endfunction

    assign trigger = (state == IDLE) && show_result && !show_q;
    assign neg_in  = (SIGNED_MODE != 0) && result[15];
    assign mag_in  = neg_in ? (~result + 16'd1) : result;
    assign bcd_adj = bcd_adjust(bcd);

    // Running "all digits so far are zero" flags drive leading-zero blanking.
    assign zpre[0] = (bcd[19:16] == 4'd0);
    assign zpre[1] = zpre[0] && (bcd[15:12] == 4'd0);
    assign zpre[2] = zpre[1] && (bcd[11:8] == 4'd0);
    assign zpre[3] = zpre[2] && (bcd[7:4] == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            show_q <= 1'b0;
            neg    <= 1'b0;
            mag    <= 16'd0;
            bcd    <= 20'd0;
            cnt    <= 4'd0;
            idx    <= 3'd0;
        end else begin
            state  <= state_nx;
            show_q <= show_result;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        neg <= neg_in;
                        mag <= mag_in;
                        bcd <= 20'd0;
                        cnt <= 4'd0;
                        idx <= 3'd0;
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= 36'({bcd_adj, mag} << 1);
                    cnt        <= cnt + 4'd1;
                end
                EMIT: begin
                    if (char_ready)
                        idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        char_data  = 8'h00;
        char_pos   = 4'h0;
        char_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger)
                    state_nx = CONVERT;
            end
            CONVERT: begin
                busy = 1'b1;
                if (cnt == 4'd15)
                    state_nx = EMIT;
            end
            EMIT: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_pos   = 4'(START_POS + 32'(idx));
                case (idx)
                    3'd0:    char_data = neg ? 8'h2D : 8'h20;
                    3'd1:    char_data = digit_char(bcd[19:16], zpre[0]);
                    3'd2:    char_data = digit_char(bcd[15:12], zpre[1]);
                    3'd3:    char_data = digit_char(bcd[11:8],  zpre[2]);
                    3'd4:    char_data = digit_char(bcd[7:4],   zpre[3]);
                    default: char_data = digit_char(bcd[3:0],   1'b0);
                endcase
                if (char_ready && idx == 3'd5)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_result_formatter.sv
// Bench for lcd_result_formatter: three parameterisations share stimulus and
// each has its own scoreboard of expected {pos, char} words.
module tb_lcd_result_formatter;

    logic        clk;
    logic        reset;
    logic [15:0] result;
    logic        show_result;
    logic        char_ready;
    logic [7:0]  cd [3];
    logic [3:0]  cp [3];
    logic        cv [3];
    logic        bz [3];
    logic        dn [3];

    int total = 0;
    int bad   = 0;

    logic [11:0] sb0[$];
    logic [11:0] sb1[$];
    logic [11:0] sb2[$];
    bit          stall_prev [3];
    logic [11:0] stall_word [3];

    lcd_result_formatter #(.SIGNED_MODE(1), .START_POS(0)) dut_s (
        .clk(clk), .reset(reset), .result(result), .show_result(show_result),
        .char_data(cd[0]), .char_pos(cp[0]), .char_valid(cv[0]), .char_ready(char_ready),
        .busy(bz[0]), .done(dn[0]));

    lcd_result_formatter #(.SIGNED_MODE(0), .START_POS(0)) dut_u (
        .clk(clk), .reset(reset), .result(result), .show_result(show_result),
        .char_data(cd[1]), .char_pos(cp[1]), .char_valid(cv[1]), .char_ready(char_ready),
        .busy(bz[1]), .done(dn[1]));

    lcd_result_formatter #(.SIGNED_MODE(1), .START_POS(12)) dut_p (
        .clk(clk), .reset(reset), .result(result), .show_result(show_result),
        .char_data(cd[2]), .char_pos(cp[2]), .char_valid(cv[2]), .char_ready(char_ready),
        .busy(bz[2]), .done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sb_size(input int i);
        case (i)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic logic [11:0] sb_pop(input int i);
        case (i)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    // Reference: decimal digits by division, sign, leading-zero blanking.
    task automatic push_expected(input logic [15:0] r);
        for (int i = 0; i < 3; i++) begin
            bit          sm;
            int          sp;
            bit          ng;
            bit          lead;
            int          m;
            int          d;
            int          dig [5];
            logic [7:0]  ch;
            logic [11:0] w;
            sm = (i != 1);
            sp = (i == 2) ? 12 : 0;
            ng = sm && r[15];
            m  = ng ? 65536 - int'(r) : int'(r);
            dig[0] = (m / 10000) % 10;
            dig[1] = (m / 1000) % 10;
            dig[2] = (m / 100) % 10;
            dig[3] = (m / 10) % 10;
            dig[4] = m % 10;
            lead = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (k == 0) begin
                    ch = ng ? 8'h2D : 8'h20;
                end else begin
                    d = dig[k-1];
                    if (d != 0 || k == 5)
                        lead = 1'b0;
                    ch = lead ? 8'h20 : 8'(8'h30 + d);
                end
                w = {4'((sp + k) % 16), ch};
                case (i)
                    0:       sb0.push_back(w);
                    1:       sb1.push_back(w);
                    default: sb2.push_back(w);
                endcase
            end
        end
    endtask

    // Scoreboard step: check what the coming edge will accept, then advance one cycle.
    task automatic cycle();
        for (int i = 0; i < 3; i++) begin
            logic [11:0] got;
            logic [11:0] exp;
            got = {cp[i], cd[i]};
            if (stall_prev[i]) begin
                total++;
                if (cv[i] !== 1'b1 || got !== stall_word[i]) begin
                    bad++;
                    $display("FAIL stall_hold inst%0d: got valid=%b word=%h, required valid=1 word=%h",
                             i, cv[i], got, stall_word[i]);
                end
            end
            if (cv[i] === 1'b1 && char_ready === 1'b1) begin
                total++;
                if (sb_size(i) == 0) begin
                    bad++;
                    $display("FAIL unexpected_char inst%0d: got word=%h, required no character", i, got);
                end else begin
                    exp = sb_pop(i);
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL char inst%0d: got pos=%0d char=%h, required pos=%0d char=%h",
                                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
                    end
                end
            end
            stall_prev[i] = (cv[i] === 1'b1) && (char_ready !== 1'b1);
            stall_word[i] = got;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_conv(input logic [15:0] r);
        result      = r;
        show_result = 1'b1;
        push_expected(r);
    endtask

    // mode 0: drop show_result after trigger; 1: hold high; 2: toggle during CONVERT.
    task automatic run_conv(input int mode, input int stall_at, input int stall_len,
                            output int t_valid, output int t_done, output logic busy1,
                            output logic [2:0] dn_mask, output logic [2:0] bz_done,
                            output int n_hold);
        int acc;
        int stalled;
        acc = 0; stalled = 0; t_valid = -1; t_done = -1; busy1 = 1'b0;
        dn_mask = 3'b000; bz_done = 3'b111; n_hold = 0;
        for (int k = 1; k <= 80 && t_done < 0; k++) begin
            if (cv[0] && acc == stall_at && stalled < stall_len) begin
                char_ready = 1'b0;
                stalled++;
            end else begin
                char_ready = 1'b1;
            end
            if (cv[0] && char_ready) acc++;
            if (cv[0] && cp[0] == 4'd2) n_hold++;
            case (mode)
                0: if (k == 2) show_result = 1'b0;
                2: begin
                    if (k == 3) show_result = 1'b0;
                    if (k == 5) show_result = 1'b1;
                    if (k == 8) show_result = 1'b0;
                end
                default: ;
            endcase
            cycle();
            if (k == 1) busy1 = bz[0];
            if (cv[0] && t_valid < 0) t_valid = k;
            if (dn[0]) begin
                t_done  = k;
                dn_mask = {dn[2], dn[1], dn[0]};
                bz_done = {bz[2], bz[1], bz[0]};
            end
        end
        total++;
        if (t_done < 0) begin
            bad++;
            $display("FAIL done_timeout: got no done within 80 cycles, required done");
        end
        total++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            bad++;
            $display("FAIL leftover_chars: got %0d/%0d/%0d pending, required 0/0/0",
                     sb0.size(), sb1.size(), sb2.size());
        end
        show_result = 1'b0;
        char_ready  = 1'b1;
        cycle();
    endtask

    task automatic check_timing(input string name, input int t_valid, input int t_done,
                                input logic busy1, input logic [2:0] dn_mask,
                                input logic [2:0] bz_done, input int exp_done);
        total++;
        if (t_valid !== 17) begin
            bad++;
            $display("FAIL %s_first_valid: got T+%0d, required T+17", name, t_valid);
        end
        total++;
        if (t_done !== exp_done) begin
            bad++;
            $display("FAIL %s_done_time: got T+%0d, required T+%0d", name, t_done, exp_done);
        end
        total++;
        if (busy1 !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy_start: got %b, required 1", name, busy1);
        end
        total++;
        if (dn_mask !== 3'b111 || bz_done !== 3'b000) begin
            bad++;
            $display("FAIL %s_done_busy: got done=%b busy=%b, required done=111 busy=000",
                     name, dn_mask, bz_done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cv[i] !== 1'b0 || bz[i] !== 1'b0 || dn[i] !== 1'b0 ||
                cd[i] !== 8'h00 || cp[i] !== 4'h0) begin
                bad++;
                $display("FAIL %s inst%0d: got valid=%b busy=%b done=%b data=%h pos=%h, required all 0",
                         name, i, cv[i], bz[i], dn[i], cd[i], cp[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; show_result = 1'b0; result = 16'h0000; char_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stall_prev[i] = 1'b0;
            stall_word[i] = 12'h000;
        end
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b1;
        cycle();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        int tv, td, nh; logic b1; logic [2:0] dm, bd;
        start_conv(16'h0007);
        run_conv(0, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("seven", tv, td, b1, dm, bd, 23);
    endtask

    task automatic test_signs();
        int tv, td, nh; logic b1; logic [2:0] dm, bd;
        start_conv(16'hFFFF);
        run_conv(0, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("all_ones", tv, td, b1, dm, bd, 23);
        start_conv(16'h8000);
        run_conv(0, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("min_neg", tv, td, b1, dm, bd, 23);
        start_conv(16'h0000);
        run_conv(0, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("zero", tv, td, b1, dm, bd, 23);
    endtask

    task automatic test_backpressure();
        int tv, td, nh; logic b1; logic [2:0] dm, bd;
        start_conv(16'h3039);
        run_conv(0, 2, 3, tv, td, b1, dm, bd, nh);
        check_timing("stall", tv, td, b1, dm, bd, 26);
        total++;
        if (nh !== 4) begin
            bad++;
            $display("FAIL stall_hold_cycles: got %0d cycles at pos 2, required 4", nh);
        end
    endtask

    task automatic test_retrigger_and_reset();
        int tv, td, nh; logic b1; logic [2:0] dm, bd;
        start_conv(16'h04D2);
        run_conv(2, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("retrigger", tv, td, b1, dm, bd, 23);
        for (int k = 0; k < 25; k++) begin
            cycle();
            total++;
            if (cv[0] !== 1'b0 || bz[0] !== 1'b0) begin
                bad++;
                $display("FAIL retrigger_quiet: got valid=%b busy=%b at +%0d, required 0 0", cv[0], bz[0], k);
            end
        end
        start_conv(16'h1234);
        for (int k = 0; k < 19; k++) cycle();
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_emit");
        sb0.delete(); sb1.delete(); sb2.delete();
        for (int i = 0; i < 3; i++) stall_prev[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            total++;
            if (dn[0] !== 1'b0 || dn[1] !== 1'b0 || dn[2] !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_done: got done=%b%b%b, required 000", dn[2], dn[1], dn[0]);
            end
        end
        reset = 1'b1;
        start_conv(16'h1234);
        run_conv(1, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("held_over_reset", tv, td, b1, dm, bd, 23);
    endtask

    task automatic test_start_pos();
        int tv, td, nh; logic b1; logic [2:0] dm, bd;
        start_conv(16'h0064);
        run_conv(0, -1, 0, tv, td, b1, dm, bd, nh);
        check_timing("start_pos", tv, td, b1, dm, bd, 23);
    endtask

    task automatic test_back_to_back();
        int tv, td, nh; logic b1; logic [2:0] dm, bd;
        logic [15:0] r;
        for (int n = 0; n < 4; n++) begin
            r = 16'($urandom);
            start_conv(r);
            run_conv(0, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), tv, td, b1, dm, bd, nh);
            total++;
            if (td < 23 || td > 25) begin
                bad++;
                $display("FAIL b2b_done_time: got T+%0d for %h, required T+23..T+25", td, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_backpressure();
        test_retrigger_and_reset();
        test_start_pos();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
